// File: rtl/fifo_nibble_packer.sv
// -----------------------------------------------------------------------------
// fifo_nibble_packer
//
// Drains narrow entries from a ring-buffer FIFO and packs WORDS consecutive
// entries, LSB-first, into one wide word presented on a valid/ready interface.
// A flush forces out a partially filled word, zero-padded in the unused slices.
//
// Ports
//   clock       rising-edge clock, shared with the FIFO
//   reset       synchronous, active-high reset
//   fifo_data   FIFO head entry (meaningful only while fifo_empty=0)
//   fifo_empty  FIFO empty flag
//   fifo_push   copy of the FIFO's push input (FIFO ignores pop during push)
//   fifo_pop    pop request to the FIFO (combinational)
//   flush       emit the current partial word
//   out_data    packed word, first entry in the least-significant slice
//   out_count   number of valid entries in out_data (1..WORDS)
//   out_valid   out_data/out_count valid
//   out_ready   downstream accepts the word
// -----------------------------------------------------------------------------
module fifo_nibble_packer #(
  parameter int MSBD  = 3,
  parameter int WORDS = 4,
  parameter int MSBC  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MSBD:0]               fifo_data,
  input  logic                        fifo_empty,
  input  logic                        fifo_push,
  output logic                        fifo_pop,
  input  logic                        flush,
  output logic [(MSBD+1)*WORDS-1:0]   out_data,
  output logic [MSBC:0]               out_count,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int EW = MSBD + 1;
  localparam int OW = EW * WORDS;

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state, state_nx;
  logic [MSBC:0]   cnt, cnt_nx;
  logic [OW-1:0]   acc, acc_nx;
  logic [OW-1:0]   out_data_nx;
  logic [MSBC:0]   out_count_nx;
  logic            out_valid_nx;

  logic            take;
  logic [OW-1:0]   acc_take;     // accumulator including this cycle's entry
  logic [MSBC:0]   count_take;   // entries held including this cycle's entry
  logic            complete;
  logic            flush_out;

  // Popping only while no push is in flight means the FIFO honours every pop,
  // so the pop itself marks the cycle an entry is consumed.
  assign fifo_pop = !reset && (state == FILL) && !fifo_empty && !fifo_push;
  assign take     = fifo_pop;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    acc_nx       = acc;
    out_data_nx  = out_data;
    out_count_nx = out_count;
    out_valid_nx = out_valid;

    acc_take = acc;
    if (take) acc_take[cnt*EW +: EW] = fifo_data;
    count_take = cnt + {{MSBC{1'b0}}, take};
    complete   = take && (cnt == (MSBC+1)'(WORDS - 1));
    // A flush with nothing collected is simply ignored.
    flush_out  = flush && (count_take != '0);

    case (state)
      FILL: begin
        if (complete || flush_out) begin
          state_nx     = HOLD;
          out_data_nx  = acc_take;
          out_count_nx = count_take;
          out_valid_nx = 1'b1;
        end else begin
          acc_nx = acc_take;
          cnt_nx = count_take;
        end
      end
      HOLD: begin
        // out_valid is always 1 here, so out_ready alone signals the transfer.
        if (out_ready) begin
          state_nx     = FILL;
          cnt_nx       = '0;
          acc_nx       = '0;
          out_valid_nx = 1'b0;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the accumulator is reset (not just the control) because unfilled
      // slices must read as zero in a flushed word.
      state     <= FILL;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      acc       <= acc_nx;
      out_data  <= out_data_nx;
      out_count <= out_count_nx;
      out_valid <= out_valid_nx;
    end
  end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_nibble_packer
//
// Drives fifo_nibble_packer from a queue-based FIFO model. A reference model
// tracks which entries have been collected into the current word and pushes
// each expected word onto a scoreboard; an independent monitor compares every
// presented word against the scoreboard head.
// -----------------------------------------------------------------------------
module tb_fifo_nibble_packer;

  localparam int EW    = 4;
  localparam int WORDS = 4;
  localparam int OW    = EW * WORDS;

  typedef struct {
    logic [OW-1:0] data;
    logic [2:0]    count;
  } word_t;

  logic          clock;
  logic          reset;
  logic [EW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          flush;
  logic [OW-1:0] out_data;
  logic [2:0]    out_count;
  logic          out_valid;
  logic          out_ready;

  fifo_nibble_packer #(.MSBD(3), .WORDS(4), .MSBC(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_push (fifo_push),
    .fifo_pop  (fifo_pop),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] fq[$];        // FIFO contents, head at index 0
  logic [EW-1:0] partial[$];   // entries collected into the current word
  bit            holding = 0;  // a finished word waits for the consumer
  word_t         sb[$];        // expected words in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? EW'($urandom) : fq[0];
  endtask

  task automatic preload(input logic [EW-1:0] vals[$]);
    foreach (vals[i]) fq.push_back(vals[i]);
    drive_fifo();
  endtask

  function automatic logic [OW-1:0] pack(input logic [EW-1:0] ents[$]);
    logic [OW-1:0] w;
    w = '0;
    foreach (ents[i]) w = w | (OW'(ents[i]) << (i * EW));
    return w;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check and advance
  // the model just before the rising edge, update the FIFO just after it.
  task automatic step(input bit rst, input bit psh, input logic [EW-1:0] pd,
                      input bit fl, input bit rdy);
    bit    exp_pop;
    word_t w;
    @(negedge clock);
    reset     = rst;
    fifo_push = psh;
    flush     = fl;
    out_ready = rdy;
    #4;
    exp_pop = !rst && !holding && (fq.size() > 0) && !psh;
    check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    check("out_valid", 32'(out_valid), 32'(holding));
    if (rst) begin
      holding = 0;
      partial.delete();
    end else if (holding) begin
      if (rdy) holding = 0;
    end else begin
      if (exp_pop) partial.push_back(fq[0]);
      if ((partial.size() == WORDS) || (fl && partial.size() > 0)) begin
        w.data  = pack(partial);
        w.count = 3'(partial.size());
        sb.push_back(w);
        holding = 1;
        partial.delete();
      end
    end
    @(posedge clock);
    #1;
    if (exp_pop) void'(fq.pop_front());
    if (psh) fq.push_back(pd);
    drive_fifo();
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(0, 0, '0, 0, rdy);
  endtask

  // Flush and accept until FIFO, partial word and scoreboard are all empty.
  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      if (fq.size() == 0 && partial.size() == 0 && !holding && sb.size() == 0) break;
      step(0, 0, '0, 1, 1);
    end
    check("drain_done", 32'(k < 200), 32'd1);
  endtask

  task automatic check_out(input string name, input logic [OW-1:0] d, input logic [2:0] c);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"},  32'(out_data),  32'(d));
    check({name, "_count"}, 32'(out_count), 32'(c));
  endtask

  // Monitor: compares every presented word with the scoreboard head, also
  // on stalled cycles, so a word that changes while held is caught.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
        end else begin
          check("sb_data",  32'(out_data),  32'(sb[0].data));
          check("sb_count", 32'(out_count), 32'(sb[0].count));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    fifo_push = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clock);
    #1;

    // Idle with an empty FIFO.
    step(1, 0, '0, 0, 0);
    idle(10, 0);
    check("idle_data",  32'(out_data),  32'd0);
    check("idle_count", 32'(out_count), 32'd0);

    // Full word with the consumer ready.
    preload('{4'h1, 4'h2, 4'h3, 4'h4});
    idle(4, 1);
    check_out("full", 16'h4321, 3'd4);
    idle(1, 1);
    check("full_drop", 32'(out_valid), 32'd0);
    drain();

    // Back-pressure across two words.
    preload('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8});
    idle(4, 0);
    check_out("bp_first", 16'h4321, 3'd4);
    idle(5, 0);
    check_out("bp_stall", 16'h4321, 3'd4);
    idle(1, 1);
    idle(4, 0);
    check_out("bp_second", 16'h8765, 3'd4);
    drain();

    // Push collides with the second pop.
    preload('{4'h1, 4'h2, 4'h3, 4'h4});
    step(0, 0, '0, 0, 0);
    step(0, 1, 4'h9, 0, 0);
    idle(3, 0);
    check_out("collide", 16'h4321, 3'd4);
    drain();

    // Flush after two entries with the FIFO empty.
    preload('{4'hA, 4'hB});
    idle(2, 0);
    step(0, 0, '0, 1, 0);
    check_out("flush2", 16'h00BA, 3'd2);
    drain();

    // Flush with nothing collected.
    step(0, 0, '0, 1, 0);
    idle(1, 0);
    check("flush_empty", 32'(out_valid), 32'd0);

    // Flush on the same cycle as the third pop.
    preload('{4'hA, 4'hB, 4'hC});
    idle(2, 0);
    step(0, 0, '0, 1, 0);
    check_out("flush3", 16'h0CBA, 3'd3);
    drain();

    // Reset mid-fill discards the partial word.
    preload('{4'h1, 4'h2, 4'h3});
    idle(3, 0);
    step(1, 0, '0, 0, 0);
    preload('{4'h5, 4'h6, 4'h7, 4'h8});
    idle(4, 0);
    check_out("rst_mid", 16'h8765, 3'd4);
    drain();

    // Randomized traffic.
    repeat (800) begin
      step(!holding && ($urandom_range(63) == 0),
           $urandom_range(99) < 35,
           EW'($urandom),
           $urandom_range(99) < 8,
           $urandom_range(99) < 60);
    end
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
